// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Sequencing front-end for an external 8-bit combinational ALU. Accepts one
//   register-to-register instruction at a time over a valid/ready handshake,
//   reads operands from an internal register file, presents them to the ALU,
//   captures the ALU outputs and writes the result (and, for MULTIPLY, the high
//   byte) back. Owns the registered status flags {V,S,C,Z}.
//
//   Sequence per instruction: IDLE (accept) -> EXEC (ALU settles, outputs
//   captured) -> WB (wb_valid high, regfile/sreg_q written at the end).
//
// Parameters
//   RA            register address width; NREG = 2**RA entries of 8 bits
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   instr_valid/instr_ready         instruction handshake (ready only in IDLE)
//   instr_op, instr_rd, instr_rs    opcode, destination/operand-A reg, operand-B reg
//   alu_A, alu_B, alu_fsl           registered operands/opcode to the ALU
//   alu_result, alu_mul_high,
//   alu_sreg                        ALU outputs
//   sreg_q                          registered status {V,S,C,Z}
//   wb_valid, wb_addr, wb_data      retire pulse with written address/value
//   dbg_addr, dbg_data              combinational regfile read port
//
// Optional feature (macro ALU_IMM_EN)
//   Adds instr_use_imm / instr_imm; when instr_use_imm is high at accept the
//   immediate replaces rf[rs] as operand B.
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [RA-1:0] instr_rd,
  input  logic [RA-1:0] instr_rs,
`ifdef ALU_IMM_EN
  input  logic          instr_use_imm,
  input  logic [7:0]    instr_imm,
`endif
  output logic [7:0]    alu_A,
  output logic [7:0]    alu_B,
  output logic [3:0]    alu_fsl,
  input  logic [7:0]    alu_result,
  input  logic [7:0]    alu_mul_high,
  input  logic [3:0]    alu_sreg,
  output logic [3:0]    sreg_q,
  output logic          wb_valid,
  output logic [RA-1:0] wb_addr,
  output logic [7:0]    wb_data,
  input  logic [RA-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  localparam int         NREG   = 2**RA;
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_CMP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          accept;

  logic [7:0]    rf_q [NREG];
  logic [7:0]    alu_a_q, alu_b_q;
  logic [3:0]    fsl_q;
  logic [RA-1:0] rd_q;
  logic [RA-1:0] rd_hi;
  logic [7:0]    res_q, mulh_q;
  logic [3:0]    sreg_hold_q;
  logic          wb_valid_q;
  logic [RA-1:0] wb_addr_q;
  logic [7:0]    wb_data_q;
  logic [7:0]    opb_d;

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Operand B source selection at accept time.
  always_comb begin
    opb_d = rf_q[instr_rs];
`ifdef ALU_IMM_EN
    if (instr_use_imm) opb_d = instr_imm;
`endif
  end

  // High byte of a product lands in the next register, wrapping past NREG-1.
  assign rd_hi = rd_q + RA'(1);

  // ---------------------------------------------------------------------------
  // Issue / capture / write-back datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      fsl_q       <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      mulh_q      <= '0;
      sreg_hold_q <= '0;
      sreg_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      wb_valid_q <= 1'b0;

      // Operands stay on the ALU bus until the next accept.
      if (accept) begin
        alu_a_q <= rf_q[instr_rd];
        alu_b_q <= opb_d;
        fsl_q   <= instr_op;
        rd_q    <= instr_rd;
      end

      // End of EXEC: ALU has settled; capture and raise the retire pulse for WB.
      if (state_q == S_EXEC) begin
        res_q       <= alu_result;
        mulh_q      <= alu_mul_high;
        sreg_hold_q <= alu_sreg;
        wb_valid_q  <= 1'b1;
        wb_addr_q   <= rd_q;
        wb_data_q   <= (fsl_q == OP_CMP) ? 8'h00 : alu_result;
      end

      // End of WB: commit; dbg reads see the old value throughout WB.
      if (state_q == S_WB) begin
        sreg_q <= sreg_hold_q;
        if (fsl_q != OP_CMP) rf_q[rd_q]  <= res_q;
        if (fsl_q == OP_MUL) rf_q[rd_hi] <= mulh_q;
      end
    end
  end

  assign alu_A    = alu_a_q;
  assign alu_B    = alu_b_q;
  assign alu_fsl  = fsl_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int RA   = 3;
  localparam int NREG = 2**RA;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [RA-1:0] instr_rd, instr_rs;
  logic          instr_use_imm;
  logic [7:0]    instr_imm;
  logic [7:0]    alu_A, alu_B;
  logic [3:0]    alu_fsl;
  logic [7:0]    alu_result, alu_mul_high;
  logic [3:0]    alu_sreg;
  logic [3:0]    sreg_q;
  logic          wb_valid;
  logic [RA-1:0] wb_addr;
  logic [7:0]    wb_data;
  logic [RA-1:0] dbg_addr;
  logic [7:0]    dbg_data;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [7:0]    mdl_rf [NREG];
  logic [3:0]    mdl_sreg;
  logic [7:0]    last_wb_data;
  logic [RA-1:0] last_wb_addr;

  // Bench-side ALU; force mode lets the bench load arbitrary register values.
  logic          force_en;
  logic [7:0]    force_val;
  logic [19:0]   alu_bits;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.RA(RA)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs     (instr_rs),
`ifdef ALU_IMM_EN
    .instr_use_imm(instr_use_imm),
    .instr_imm    (instr_imm),
`endif
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_fsl      (alu_fsl),
    .alu_result   (alu_result),
    .alu_mul_high (alu_mul_high),
    .alu_sreg     (alu_sreg),
    .sreg_q       (sreg_q),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  // ALU behaviour: returns {V,S,C,Z, mul_high[7:0], result[7:0]}
  function automatic logic [19:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r, h;
    logic        v, c, z;
    s = '0; p = '0; h = 8'h00;
    case (op)
      4'h0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'hE: begin
        p = 16'(a) * 16'(b);
        r = p[7:0]; h = p[15:8];
        c = |h; v = 1'b0;
      end
      4'hF: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: begin
        r = (a ^ {b[3:0], b[7:4]}) + {4'h0, op};
        c = r[0] ^ op[1];
        v = op[0] & b[7];
      end
    endcase
    z = (op == 4'hE) ? (p == 16'h0) : (r == 8'h00);
    return {v, r[7], c, z, h, r};
  endfunction

  always_comb begin
    alu_bits = alu_ref(alu_A, alu_B, alu_fsl);
    if (force_en) alu_bits[7:0] = force_val;
  end
  assign alu_result   = alu_bits[7:0];
  assign alu_mul_high = alu_bits[15:8];
  assign alu_sreg     = alu_bits[19:16];

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_rf(input string tag);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = RA'(i);
      #1;
      checks++;
      if (dbg_data !== mdl_rf[i]) begin
        failures++;
        $display("FAIL %s rf[%0d] got=%h exp=%h", tag, i, dbg_data, mdl_rf[i]);
      end
    end
  endtask

  // One full instruction with checks at every phase against the model.
  task automatic issue(input logic [3:0] op, input int rd, input int rs,
                       input logic use_imm, input logic [7:0] imm,
                       input logic fen, input logic [7:0] fval);
    logic [19:0] e;
    logic [7:0]  a, b, expd, old_rd;
    int          w;
    a    = mdl_rf[rd];
    b    = use_imm ? imm : mdl_rf[rs];
    e    = alu_ref(a, b, op);
    if (fen) e[7:0] = fval;
    expd = (op == 4'hF) ? 8'h00 : e[7:0];
    old_rd = mdl_rf[rd];

    @(posedge clk); #1;
    w = 0;
    while (instr_ready !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL ready_wait got=%b exp=1", instr_ready);
    end
    force_en = fen; force_val = fval;
    instr_valid = 1'b1; instr_op = op; instr_rd = RA'(rd); instr_rs = RA'(rs);
    instr_use_imm = use_imm; instr_imm = imm;
    @(posedge clk); #1;
    instr_valid = 1'b0;

    // EXEC
    checks += 5;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL exec_ready got=%b exp=0", instr_ready); end
    if (alu_A !== a)          begin failures++; $display("FAIL alu_A got=%h exp=%h", alu_A, a); end
    if (alu_B !== b)          begin failures++; $display("FAIL alu_B got=%h exp=%h", alu_B, b); end
    if (alu_fsl !== op)       begin failures++; $display("FAIL alu_fsl got=%h exp=%h", alu_fsl, op); end
    if (wb_valid !== 1'b0)    begin failures++; $display("FAIL exec_wbv got=%b exp=0", wb_valid); end
    @(posedge clk); #1;

    // WB
    force_en = 1'b0;
    last_wb_data = wb_data; last_wb_addr = wb_addr;
    checks += 5;
    if (wb_valid !== 1'b1)     begin failures++; $display("FAIL wb_valid got=%b exp=1", wb_valid); end
    if (wb_addr !== RA'(rd))   begin failures++; $display("FAIL wb_addr got=%0d exp=%0d", wb_addr, rd); end
    if (wb_data !== expd)      begin failures++; $display("FAIL wb_data got=%h exp=%h", wb_data, expd); end
    if (sreg_q !== mdl_sreg)   begin failures++; $display("FAIL wb_sreg_old got=%h exp=%h", sreg_q, mdl_sreg); end
    dbg_addr = RA'(rd); #1;
    if (dbg_data !== old_rd)   begin failures++; $display("FAIL dbg_prewrite got=%h exp=%h", dbg_data, old_rd); end
    @(posedge clk); #1;

    // Back in IDLE: apply the instruction to the model
    if (op != 4'hF) mdl_rf[rd] = e[7:0];
    if (op == 4'hE) mdl_rf[(rd + 1) % NREG] = e[15:8];
    mdl_sreg = e[19:16];
    checks += 3;
    if (wb_valid !== 1'b0)     begin failures++; $display("FAIL wb_pulse got=%b exp=0", wb_valid); end
    if (instr_ready !== 1'b1)  begin failures++; $display("FAIL idle_ready got=%b exp=1", instr_ready); end
    if (sreg_q !== mdl_sreg)   begin failures++; $display("FAIL sreg got=%h exp=%h", sreg_q, mdl_sreg); end
    check_rf("post_wb");
  endtask

  task automatic load(input int r, input logic [7:0] v);
    issue(4'h1, r, 0, 1'b0, 8'h00, 1'b1, v);
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
    instr_use_imm = 1'b0; instr_imm = '0; dbg_addr = '0; force_en = 1'b0; force_val = '0;
    for (int i = 0; i < NREG; i++) mdl_rf[i] = 8'h00;
    mdl_sreg = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", instr_ready); end
    if (sreg_q !== 4'h0)      begin failures++; $display("FAIL rst_sreg got=%h exp=0", sreg_q); end
    if (wb_valid !== 1'b0)    begin failures++; $display("FAIL rst_wbv got=%b exp=0", wb_valid); end
    if (alu_A !== 8'h00)      begin failures++; $display("FAIL rst_alu_A got=%h exp=0", alu_A); end
    if (alu_B !== 8'h00)      begin failures++; $display("FAIL rst_alu_B got=%h exp=0", alu_B); end
    if ({wb_addr, wb_data, alu_fsl} !== '0) begin
      failures++; $display("FAIL rst_wb got=%h exp=0", {wb_addr, wb_data, alu_fsl});
    end
    check_rf("reset");
    reset = 1'b0;
  endtask

  task automatic test_add_overflow();
    load(1, 8'h7F);
    load(2, 8'h01);
    issue(4'h0, 1, 2, 1'b0, 8'h00, 1'b0, 8'h00);
    checks += 3;
    if (last_wb_data !== 8'h80) begin failures++; $display("FAIL add_wb_data got=%h exp=80", last_wb_data); end
    if (sreg_q !== 4'b1100)     begin failures++; $display("FAIL add_sreg got=%b exp=1100", sreg_q); end
    dbg_addr = RA'(1); #1;
    if (dbg_data !== 8'h80)     begin failures++; $display("FAIL add_rf1 got=%h exp=80", dbg_data); end
  endtask

  task automatic test_mul_wrap();
    load(7, 8'h10);
    load(0, 8'h20);
    issue(4'hE, 7, 0, 1'b0, 8'h00, 1'b0, 8'h00);
    checks += 3;
    if (last_wb_addr !== RA'(7)) begin failures++; $display("FAIL mul_wb_addr got=%0d exp=7", last_wb_addr); end
    dbg_addr = RA'(7); #1;
    if (dbg_data !== 8'h00)      begin failures++; $display("FAIL mul_rf7 got=%h exp=00", dbg_data); end
    dbg_addr = RA'(0); #1;
    if (dbg_data !== 8'h02)      begin failures++; $display("FAIL mul_rf0 got=%h exp=02", dbg_data); end
  endtask

  task automatic test_compare();
    load(3, 8'($urandom_range(0, 255)));
    issue(4'hF, 3, 3, 1'b0, 8'h00, 1'b0, 8'h00);
    checks += 2;
    if (last_wb_data !== 8'h00) begin failures++; $display("FAIL cmp_wb_data got=%h exp=00", last_wb_data); end
    if (sreg_q[0] !== 1'b1)     begin failures++; $display("FAIL cmp_z got=%b exp=1", sreg_q[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic ui;
      ui = 1'b0;
`ifdef ALU_IMM_EN
      ui = 1'($urandom_range(0, 1));
`endif
      issue(4'($urandom_range(0, 15)), $urandom_range(0, NREG-1), $urandom_range(0, NREG-1),
            ui, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_op = 4'hF; instr_rd = RA'(2); instr_rs = RA'(2);
    instr_use_imm = 1'b0;
    w = 0;
    while (instr_ready !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
    for (int k = 0; k < 9; k++) begin
      checks += 2;
      if (instr_ready !== (k % 3 == 0)) begin
        failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, instr_ready, (k % 3 == 0));
      end
      if (wb_valid !== (k % 3 == 2)) begin
        failures++; $display("FAIL b2b_wbv k=%0d got=%b exp=%b", k, wb_valid, (k % 3 == 2));
      end
      @(posedge clk); #1;
    end
    // Now in IDLE with valid still high: next edge accepts, then reset in EXEC.
    @(posedge clk); #1;
    checks++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL b2b_exec got=%b exp=0", instr_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; instr_valid = 1'b0;
    for (int i = 0; i < NREG; i++) mdl_rf[i] = 8'h00;
    mdl_sreg = 4'h0;
    checks += 3;
    if (wb_valid !== 1'b0)    begin failures++; $display("FAIL abort_wbv got=%b exp=0", wb_valid); end
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", instr_ready); end
    if (sreg_q !== 4'h0)      begin failures++; $display("FAIL abort_sreg got=%h exp=0", sreg_q); end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0)    begin failures++; $display("FAIL abort_wbv2 got=%b exp=0", wb_valid); end
    check_rf("abort");
  endtask

`ifdef ALU_IMM_EN
  task automatic test_imm();
    load(2, 8'h05);
    issue(4'h0, 2, 5, 1'b1, 8'hFB, 1'b0, 8'h00);
    checks += 3;
    if (last_wb_data !== 8'h00) begin failures++; $display("FAIL imm_wb_data got=%h exp=00", last_wb_data); end
    if (sreg_q[0] !== 1'b1)     begin failures++; $display("FAIL imm_z got=%b exp=1", sreg_q[0]); end
    if (sreg_q[1] !== 1'b1)     begin failures++; $display("FAIL imm_c got=%b exp=1", sreg_q[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_overflow();
    test_mul_wrap();
    test_compare();
`ifdef ALU_IMM_EN
    test_imm();
`endif
    test_random();
    test_back_to_back();
    test_add_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
